scr1_mdu_trace_mon: RTL and testbench
=====================================

# scr1_mdu_trace_mon

Parametrised M-extension instruction trace monitor for the SCR1 AHB testbench top. It watches the instruction-memory response bus and decodes all eight MUL/DIV/REM operations, not only DIV. For each decoded operation it keeps per-operation counters and pushes a trace record (operation, destination, operands) into a configurable-depth FIFO drained by a valid/ready consumer. The bench instantiates it beside the core and feeds it register-file operand values.

## Interface
- XLEN, 32: operand width.
- FIFO_DEPTH, 4: trace FIFO entries; power of two, ≥2.
- CNT_W, 16: width of each per-operation counter and the drop counter.
- OP_MASK, 8'hFF: bit n set enables capture and counting of funct3 = n.

- clk  in  1  monitor clock (core clock).
- rst  in  1  asynchronous, active-high reset.
- imem_resp  in  2  IMEM response; 2'b01 = valid data.
- imem_rdata  in  32  IMEM read data (instruction word).
- rs1_data  in  XLEN  register-file value of rs1 field, same cycle.
- rs2_data  in  XLEN  register-file value of rs2 field, same cycle.
- trc_valid  out  1  FIFO head valid.
- trc_ready  in  1  consumer accepts head.
- trc_funct3  out  3  head operation code.
- trc_rd  out  5  head destination register.
- trc_rs1  out  XLEN  head dividend / multiplicand.
- trc_rs2  out  XLEN  head divisor / multiplier.
- trc_exc  out  2  head flags: [0] divide-by-zero, [1] signed overflow.
- op_cnt  out  8*CNT_W  per-funct3 counters; slice n = funct3 n.
- drop_cnt  out  CNT_W  records lost to full FIFO.
- ovf  out  1  sticky: at least one record dropped.
- ovf_clr  in  1  clears ovf and drop_cnt.

## Operation
- Match: imem_resp == 2'b01, imem_rdata[6:0] == 7'b0110011, imem_rdata[31:25] == 7'b0000001, OP_MASK[funct3] == 1.
- On match: record {funct3, rd, rs1_data, rs2_data, exc} is pushed; op_cnt[funct3] increments.
- Counters saturate at 2^CNT_W−1; they never wrap.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit pointers. Full when pointers differ only in the MSB; empty when equal.
- Pop occurs when trc_valid && trc_ready. Head outputs hold stable while trc_valid && !trc_ready.
- Push when full with a same-cycle pop: both occur and the record is kept. Push when full without a pop: record dropped, drop_cnt increments (saturating), ovf set.
- Push when empty: the record appears on the head the next cycle. There is no combinational bypass.
- ovf_clr on the same cycle as a drop: the clear wins; ovf = 0 and drop_cnt = 0.
- Non-matching or non-valid responses change no state.

## Timing
- Reset values: trc_valid 0, trc_funct3/trc_rd/trc_rs1/trc_rs2/trc_exc 0, op_cnt all 0, drop_cnt 0, ovf 0. FIFO pointers are reset to empty.
- Capture latency: 1 cycle from the matching clk edge to trc_valid and op_cnt update.
- Reset asserted mid-operation clears all state immediately (asynchronously) and discards queued records. Capture resumes on the first clk edge after rst deasserts.
- At most one capture per cycle.

## Configuration
- SCR1_MDU_TRACE_EXC_EN defined:
  - trc_exc[0] = funct3[2] && rs2_data == 0.
  - trc_exc[1] = (funct3 == 3'b100 || funct3 == 3'b110) && rs1_data == {1'b1, {XLEN-1{1'b0}}} && rs2_data == all-ones.
- Not defined: trc_exc is constant 0 and the comparators are not built. Port list is unchanged.

## Test plan
- Reset then DIV x5, x6 with rs1 = 100, rs2 = 7, resp 01:
  - next cycle trc_valid = 1, trc_funct3 = 4, trc_rs1 = 100, trc_rs2 = 7.
  - op_cnt[4] = 1, all other counters 0.
- DIV with resp = 2'b00, and ADD (funct7 = 0) with resp 01: no push, counters unchanged.
- With trc_ready = 0, issue 5 MULs at FIFO_DEPTH = 4:
  - 4 stored, drop_cnt = 1, ovf = 1, op_cnt[0] = 5.
  - Then pulse ovf_clr: ovf = 0, drop_cnt = 0.
- Full FIFO, MULHU pushed on the same cycle as a pop: no drop. The next 4 pops return the original 3 plus the MULHU, in order.
- With macro defined:
  - REM with rs2 = 0: trc_exc = 2'b01.
  - DIV with 0x8000_0000 / 0xFFFF_FFFF: trc_exc = 2'b10.
  - Without macro: trc_exc = 0 in both cases.
- OP_MASK = 8'h10, issue MUL then DIV: only the DIV is queued; op_cnt[0] = 0, op_cnt[4] = 1.
- Assert rst while 2 entries are queued: trc_valid drops to 0 in the same cycle and all counters read 0.

Source files
------------

// File: rtl/scr1_mdu_trace_mon.sv
// M-extension trace monitor: decodes MUL/DIV/REM on the IMEM response bus, counts
// each funct3 and queues trace records. Optional flags via SCR1_MDU_TRACE_EXC_EN.
module scr1_mdu_trace_mon #(
    parameter int          XLEN       = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 16,
    parameter logic [7:0]  OP_MASK    = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           imem_resp,
    input  logic [31:0]          imem_rdata,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    output logic                 trc_valid,
    input  logic                 trc_ready,
    output logic [2:0]           trc_funct3,
    output logic [4:0]           trc_rd,
    output logic [XLEN-1:0]      trc_rs1,
    output logic [XLEN-1:0]      trc_rs2,
    output logic [1:0]           trc_exc,
    output logic [8*CNT_W-1:0]   op_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [1:0]      exc;
    } rec_t;

    rec_t             r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt [8];
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_ovf;

    logic       w_empty;
    logic       w_full;
    logic       w_match;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [2:0] w_funct3;
    logic [1:0] w_exc;
    rec_t       w_rec;
    rec_t       w_head;

    assign w_funct3 = imem_rdata[14:12];
    assign w_match  = (imem_resp == 2'b01) && (imem_rdata[6:0] == 7'b0110011)
                   && (imem_rdata[31:25] == 7'b0000001) && OP_MASK[w_funct3];

`ifdef SCR1_MDU_TRACE_EXC_EN
    assign w_exc[0] = w_funct3[2] && (rs2_data == '0);
    assign w_exc[1] = ((w_funct3 == 3'b100) || (w_funct3 == 3'b110))
                   && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
`else
    assign w_exc = 2'b00;
`endif

    assign w_rec   = '{funct3: w_funct3, rd: imem_rdata[11:7], rs1: rs1_data,
                       rs2: rs2_data, exc: w_exc};
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign w_pop   = !w_empty && trc_ready;
    assign w_push  = w_match && (!w_full || w_pop);
    assign w_drop  = w_match && w_full && !w_pop;

    // NOTE: record storage has no reset; head fields are masked by trc_valid,
    // so stale contents are never visible and the RAM needs no reset network.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end

    // NOTE: all state below uses non-blocking assignments so every read in this
    // cycle sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
            for (int n = 0; n < 8; n++) r_cnt[n] <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            for (int n = 0; n < 8; n++) begin
                if (w_match && (w_funct3 == 3'(n)) && (r_cnt[n] != '1))
                    r_cnt[n] <= r_cnt[n] + 1'b1;
            end
            if (ovf_clr) begin
                r_drop_cnt <= '0;
                r_ovf      <= 1'b0;
            end else if (w_drop) begin
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign trc_valid  = !w_empty;
    assign trc_funct3 = trc_valid ? w_head.funct3 : '0;
    assign trc_rd     = trc_valid ? w_head.rd     : '0;
    assign trc_rs1    = trc_valid ? w_head.rs1    : '0;
    assign trc_rs2    = trc_valid ? w_head.rs2    : '0;
    assign trc_exc    = trc_valid ? w_head.exc    : '0;
    assign drop_cnt   = r_drop_cnt;
    assign ovf        = r_ovf;

    // NOTE: default assignment first so the partial-slice loop cannot infer a latch.
    always_comb begin
        op_cnt = '0;
        for (int n = 0; n < 8; n++) op_cnt[n*CNT_W +: CNT_W] = r_cnt[n];
    end

endmodule

// File: tb/tb_scr1_mdu_trace_mon.sv
// Directed bench for scr1_mdu_trace_mon: a full-mask instance plus an
// OP_MASK=8'h10 instance with 2-bit counters to reach saturation quickly.
module tb_scr1_mdu_trace_mon;

    localparam int XLEN = 32;

`ifdef SCR1_MDU_TRACE_EXC_EN
    localparam logic [1:0] EXC_DZ = 2'b01;
    localparam logic [1:0] EXC_OV = 2'b10;
`else
    localparam logic [1:0] EXC_DZ = 2'b00;
    localparam logic [1:0] EXC_OV = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      imem_resp = 2'b00;
    logic [31:0]     imem_rdata = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic            trc_ready = 1'b0;
    logic            ovf_clr = 1'b0;

    logic            trc_valid, ovf;
    logic [2:0]      trc_funct3;
    logic [4:0]      trc_rd;
    logic [XLEN-1:0] trc_rs1, trc_rs2;
    logic [1:0]      trc_exc;
    logic [127:0]    op_cnt;
    logic [15:0]     drop_cnt;

    logic            m_valid, m_ovf;
    logic [2:0]      m_funct3;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_rs1, m_rs2;
    logic [1:0]      m_exc;
    logic [15:0]     m_op_cnt;
    logic [1:0]      m_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scr1_mdu_trace_mon #(.XLEN(XLEN), .FIFO_DEPTH(4), .CNT_W(16), .OP_MASK(8'hFF)) u_dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .trc_valid(trc_valid),
        .trc_ready(trc_ready), .trc_funct3(trc_funct3), .trc_rd(trc_rd),
        .trc_rs1(trc_rs1), .trc_rs2(trc_rs2), .trc_exc(trc_exc), .op_cnt(op_cnt),
        .drop_cnt(drop_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    scr1_mdu_trace_mon #(.XLEN(XLEN), .FIFO_DEPTH(4), .CNT_W(2), .OP_MASK(8'h10)) u_msk (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .trc_valid(m_valid),
        .trc_ready(trc_ready), .trc_funct3(m_funct3), .trc_rd(m_rd),
        .trc_rs1(m_rs1), .trc_rs2(m_rs2), .trc_exc(m_exc), .op_cnt(m_op_cnt),
        .drop_cnt(m_drop_cnt), .ovf(m_ovf), .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input int n);
        return op_cnt[n*16 +: 16];
    endfunction

    function automatic logic [1:0] m_cnt(input int n);
        return m_op_cnt[n*2 +: 2];
    endfunction

    // All tasks start and end at a falling edge; one rising edge passes inside.
    task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [1:0] resp = 2'b01, input logic [6:0] f7 = 7'h01,
                         input logic rdy = 1'b0);
        imem_rdata = {f7, 5'd6, 5'd5, f3, rd, 7'b0110011};
        imem_resp  = resp;
        rs1_data   = a;
        rs2_data   = b;
        trc_ready  = rdy;
        @(negedge clk);
        imem_resp  = 2'b00;
        trc_ready  = 1'b0;
    endtask

    task automatic pop();
        trc_ready = 1'b1;
        @(negedge clk);
        trc_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_rs1 [4];
        logic [2:0]  exp_f3  [4];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", trc_valid, 0);
        check("rst_rs1", trc_rs1, 0);
        check("rst_exc", trc_exc, 0);
        check("rst_op_cnt_lo", op_cnt[63:0], 0);
        check("rst_op_cnt_hi", op_cnt[127:64], 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // DIV x10, x5, x6 with 100 / 7
        issue(3'd4, 5'd10, 100, 7);
        check("div_valid", trc_valid, 1);
        check("div_funct3", trc_funct3, 4);
        check("div_rd", trc_rd, 10);
        check("div_rs1", trc_rs1, 100);
        check("div_rs2", trc_rs2, 7);
        check("div_exc", trc_exc, 0);
        for (int n = 0; n < 8; n++)
            check($sformatf("div_cnt%0d", n), cnt(n), (n == 4) ? 1 : 0);

        // Non-valid response and non-M opcode change nothing
        issue(3'd4, 5'd11, 1, 2, 2'b00);
        issue(3'd0, 5'd12, 3, 4, 2'b01, 7'h00);
        check("nomatch_cnt4", cnt(4), 1);
        check("nomatch_cnt0", cnt(0), 0);
        check("nomatch_head", trc_rs1, 100);
        pop();
        check("nomatch_single_entry", trc_valid, 0);

        // Overflow: 5 MULs into a 4-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 5; i++) issue(3'd0, 5'd1, 32'(i + 1), 32'd2);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_cnt0", cnt(0), 5);
        check("ovf_head", trc_rs1, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_drop", drop_cnt, 0);
        check("clr_keep_valid", trc_valid, 1);

        // Full FIFO: MULHU pushed with a same-cycle pop is kept
        issue(3'd3, 5'd7, 99, 0, 2'b01, 7'h01, 1'b1);
        check("fullpop_drop", drop_cnt, 0);
        check("fullpop_ovf", ovf, 0);
        check("fullpop_cnt3", cnt(3), 1);
        exp_rs1 = '{2, 3, 4, 99};
        exp_f3  = '{0, 0, 0, 3};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("order%0d_valid", i), trc_valid, 1);
            check($sformatf("order%0d_rs1", i), trc_rs1, exp_rs1[i]);
            check($sformatf("order%0d_f3", i), trc_funct3, exp_f3[i]);
            pop();
        end
        check("drained_valid", trc_valid, 0);

        // Exception flags
        issue(3'd6, 5'd3, 5, 0);
        check("rem_dz_exc", trc_exc, EXC_DZ);
        pop();
        issue(3'd4, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ov_exc", trc_exc, EXC_OV);
        pop();
        issue(3'd5, 5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divu_no_exc", trc_exc, 0);
        pop();
        issue(3'd0, 5'd3, 9, 0);
        check("mul_zero_no_exc", trc_exc, 0);
        pop();

        // OP_MASK = 8'h10 instance: only DIV captured; 2-bit counters saturate
        do_reset();
        issue(3'd0, 5'd1, 11, 12);
        issue(3'd4, 5'd2, 13, 14);
        check("mask_valid", m_valid, 1);
        check("mask_funct3", m_funct3, 4);
        check("mask_rs1", m_rs1, 13);
        check("mask_cnt0", m_cnt(0), 0);
        check("mask_cnt4", m_cnt(4), 1);
        for (int i = 0; i < 7; i++) issue(3'd4, 5'd2, 32'(20 + i), 1);
        check("sat_cnt4", m_cnt(4), 3);
        check("sat_drop", m_drop_cnt, 3);
        check("sat_ovf", m_ovf, 1);
        check("full_drop", drop_cnt, 5);
        check("full_cnt4", cnt(4), 8);
        check("full_cnt0", cnt(0), 1);

        // Asynchronous reset with two records queued
        do_reset();
        issue(3'd4, 5'd1, 1, 1);
        issue(3'd4, 5'd1, 2, 1);
        check("prerst_valid", trc_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("asyncrst_valid", trc_valid, 0);
        check("asyncrst_m_valid", m_valid, 0);
        check("asyncrst_cnt4", cnt(4), 0);
        check("asyncrst_m_cnt4", m_cnt(4), 0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 5'd9, 42, 1);
        check("resume_valid", trc_valid, 1);
        check("resume_rs1", trc_rs1, 42);
        check("resume_cnt0", cnt(0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
